// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / call unit.
// Holds the operation encoding and the priority encoder that chooses one
// operation per cycle from the decode/exec request lines.
package pc_pkg;

  typedef logic [2:0] pc_op_t;

  localparam pc_op_t PC_HOLD   = 3'd0;
  localparam pc_op_t PC_INC    = 3'd1;
  localparam pc_op_t PC_BRANCH = 3'd2;
  localparam pc_op_t PC_JUMP   = 3'd3;
  localparam pc_op_t PC_CALL   = 3'd4;
  localparam pc_op_t PC_RET    = 3'd5;

  // Priority: jump > call > ret > branch > en > hold. Reset is handled by the
  // registers themselves and sits above all of these.
  function automatic pc_op_t pc_sel_op(input logic jump, input logic call, input logic ret,
                                       input logic branch, input logic en);
    pc_op_t op;
    if (jump)        op = PC_JUMP;
    else if (call)   op = PC_CALL;
    else if (ret)    op = PC_RET;
    else if (branch) op = PC_BRANCH;
    else if (en)     op = PC_INC;
    else             op = PC_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset (clears depth only)
//   push_i, din_i  push din_i; ignored when full
//   pop_i          drop the top entry; ignored when empty (push wins if both)
//   top_o          current top entry (undefined when empty)
//   depth_o        number of entries held
//   full_o/empty_o combinational decodes of depth_o
module return_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               top_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          do_push, do_pop;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DW'(1);
    else if (do_pop) depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Entry contents need no reset; depth alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[IW'(depth_q)] <= din_i;
  end

  assign top_o   = mem_q[IW'(depth_q - DW'(1))];
  assign depth_o = depth_q;

endmodule

// File: rtl/pc_call_unit.sv
// Fetch-stage program counter with relative branch, absolute jump, and
// call/return through a hardware return-address stack.
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   en_i               increment when no other op is requested
//   jump_i/jump_addr_i absolute jump
//   branch_i/branch_off_i  PC-relative branch, signed offset
//   call_i/call_addr_i push addr+1 and go to call_addr_i
//   ret_i              pop the stack top into the PC
//   addr_o             registered PC
//   stack_depth_o, stack_full_o, stack_empty_o  stack status
//   fault_o            sticky overflow/underflow flag, cleared only by reset
module pc_call_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic                             jump_i,
  input  logic [ADDR_W-1:0]                jump_addr_i,
  input  logic                             branch_i,
  input  logic [ADDR_W-1:0]                branch_off_i,
  input  logic                             call_i,
  input  logic [ADDR_W-1:0]                call_addr_i,
  input  logic                             ret_i,
  output logic [ADDR_W-1:0]                addr_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth_o,
  output logic                             stack_full_o,
  output logic                             stack_empty_o,
  output logic                             fault_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] stack_top;
  logic              push, pop;
  pc_op_t            op;

  assign op       = pc_sel_op(jump_i, call_i, ret_i, branch_i, en_i);
  assign addr_inc = addr_q + ADDR_W'(1);
  assign push     = (op == PC_CALL) && !stack_full_o;
  assign pop      = (op == PC_RET) && !stack_empty_o;

  return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (addr_inc),
    .top_o   (stack_top),
    .depth_o (stack_depth_o),
    .full_o  (stack_full_o),
    .empty_o (stack_empty_o)
  );

  always_comb begin
    addr_d = addr_q;
    case (op)
      PC_INC:    addr_d = addr_inc;
      PC_BRANCH: addr_d = addr_q + branch_off_i;
      PC_JUMP:   addr_d = jump_addr_i;
      PC_CALL:   if (push) addr_d = call_addr_i;
      PC_RET:    if (pop)  addr_d = stack_top;
      default:   addr_d = addr_q;
    endcase
  end

  // Overflow/underflow are the only ways to set the flag.
  assign fault_d = fault_q || ((op == PC_CALL) && stack_full_o)
                           || ((op == PC_RET) && stack_empty_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= RESET_ADDR;
      fault_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  assign addr_o  = addr_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_pc_call_unit.sv
module tb_pc_call_unit;

  logic       clk = 1'b0;
  logic       rst, en, jump, branch, call, ret;
  logic [7:0] jump_addr, branch_off, call_addr;
  logic [7:0] addr;
  logic [2:0] stack_depth;
  logic       stack_full, stack_empty, fault;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] addr;
    int         depth;
    logic       fault;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_call_unit #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_ADDR  (8'h00)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .jump_i        (jump),
    .jump_addr_i   (jump_addr),
    .branch_i      (branch),
    .branch_off_i  (branch_off),
    .call_i        (call),
    .call_addr_i   (call_addr),
    .ret_i         (ret),
    .addr_o        (addr),
    .stack_depth_o (stack_depth),
    .stack_full_o  (stack_full),
    .stack_empty_o (stack_empty),
    .fault_o       (fault)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: the DUT updates every cycle, so one expected entry is consumed
  // just after each posedge for which stimulus queued one.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".addr"},  int'(addr), int'(e.addr));
      chk({e.name, ".depth"}, int'(stack_depth), e.depth);
      chk({e.name, ".fault"}, int'(fault), int'(e.fault));
      chk({e.name, ".full"},  int'(stack_full), int'(e.depth == 4));
      chk({e.name, ".empty"}, int'(stack_empty), int'(e.depth == 0));
    end
  end

  // Apply one cycle of inputs and queue the state expected after that edge.
  task automatic step(input bit r, input bit j, input bit c, input bit rt, input bit b,
                      input bit e, input logic [7:0] ja, input logic [7:0] ca,
                      input logic [7:0] bo, input logic [7:0] ea, input int ed,
                      input bit ef, input string nm);
    exp_t x;
    rst = r; jump = j; call = c; ret = rt; branch = b; en = e;
    jump_addr = ja; call_addr = ca; branch_off = bo;
    x.addr = ea; x.depth = ed; x.fault = ef; x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    rst = 1; en = 0; jump = 0; branch = 0; call = 0; ret = 0;
    jump_addr = 0; branch_off = 0; call_addr = 0;
    @(negedge clk);
    //    rst j c r b e  ja     ca     bo     addr  dep flt
    step(1, 0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "reset");
    step(0, 0,0,0,0,1, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, "inc1");
    step(0, 0,0,0,0,1, 8'h00, 8'h00, 8'h00, 8'h02, 0, 0, "inc2");
    step(0, 0,0,0,0,1, 8'h00, 8'h00, 8'h00, 8'h03, 0, 0, "inc3");
    step(0, 0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h03, 0, 0, "hold");
    step(0, 1,0,0,0,0, 8'hFF, 8'h00, 8'h00, 8'hFF, 0, 0, "jump_ff");
    step(0, 0,0,0,0,1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "inc_wrap");
    step(0, 1,0,0,0,0, 8'h02, 8'h00, 8'h00, 8'h02, 0, 0, "jump_02");
    step(0, 0,0,0,1,0, 8'h00, 8'h00, 8'hFC, 8'hFE, 0, 0, "branch_neg");
    step(0, 0,0,0,1,1, 8'h00, 8'h00, 8'h00, 8'hFE, 0, 0, "branch_zero");
    step(0, 0,0,0,1,0, 8'h00, 8'h00, 8'h05, 8'h03, 0, 0, "branch_wrap");
    step(0, 1,0,0,0,0, 8'h10, 8'h00, 8'h00, 8'h10, 0, 0, "jump_10");
    step(0, 0,1,0,0,0, 8'h00, 8'h40, 8'h00, 8'h40, 1, 0, "call_40");
    step(0, 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 8'h11, 0, 0, "ret_11");
    step(0, 0,1,0,0,0, 8'h00, 8'h20, 8'h00, 8'h20, 1, 0, "nest1");
    step(0, 0,1,0,0,0, 8'h00, 8'h30, 8'h00, 8'h30, 2, 0, "nest2");
    step(0, 0,1,0,0,0, 8'h00, 8'h40, 8'h00, 8'h40, 3, 0, "nest3");
    step(0, 0,1,0,0,0, 8'h00, 8'h50, 8'h00, 8'h50, 4, 0, "nest4_full");
    step(0, 0,1,0,0,1, 8'h00, 8'h60, 8'h00, 8'h50, 4, 1, "overflow");
    step(0, 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 8'h41, 3, 1, "pop4");
    step(0, 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 8'h31, 2, 1, "pop3");
    step(0, 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 8'h21, 1, 1, "pop2");
    step(0, 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 8'h12, 0, 1, "pop1");
    step(0, 0,1,0,0,0, 8'h00, 8'h44, 8'h00, 8'h44, 1, 1, "call_pre_rst");
    step(1, 0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "rst_mid");
    step(0, 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, "underflow");
    step(0, 1,0,0,0,0, 8'h33, 8'h00, 8'h00, 8'h33, 0, 1, "sticky_jump");
    step(0, 0,0,0,0,1, 8'h00, 8'h00, 8'h00, 8'h34, 0, 1, "sticky_inc");
    step(1, 0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "rst_clear");
    step(0, 1,1,0,0,1, 8'h77, 8'h88, 8'h00, 8'h77, 0, 0, "jump_over_call");
    step(0, 0,1,1,0,0, 8'h00, 8'h90, 8'h00, 8'h90, 1, 0, "call_over_ret");
    step(0, 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 8'h78, 0, 0, "ret_78");
    step(0, 1,0,0,0,0, 8'hFF, 8'h00, 8'h00, 8'hFF, 0, 0, "jump_ff2");
    step(0, 0,1,0,0,0, 8'h00, 8'h05, 8'h00, 8'h05, 1, 0, "call_at_ff");
    step(0, 0,0,1,1,0, 8'h00, 8'h00, 8'h05, 8'h00, 0, 0, "ret_over_branch");
    step(0, 0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "final_hold");
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
